// File: rtl/mem_responder.sv
// mem_responder: wait-stated word-RAM responder with a four-phase ready handshake.
module mem_responder #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] IO_ADDR     = 32'hFFFF_FFF0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic [31:0] iAddr,
  input  logic [31:0] iData,
  input  logic        iRead,
  input  logic        iWrite,
  output logic [31:0] oData,
  output logic        oRdy,
  input  logic [31:0] iPORT,
  output logic [31:0] oPORT
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  logic [31:0] ram [2**ADDR_W];
  state_t state;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] idx;
  logic [31:0] wdat;
  logic wr;
  logic io;
  logic hit;
  logic req;
  logic commit;
  logic [31:0] rd_data;
  assign req = iRead | iWrite;
  assign commit = (state == RESP) && !oRdy;
  always_ff @(posedge iClk)
    if (commit && wr && !io) ram[idx] <= wdat;
`ifdef MEM_RESPONDER_IO_EN
  assign hit = iAddr == IO_ADDR;
  assign rd_data = io ? iPORT : ram[idx];
  always_ff @(posedge iClk or negedge nRst)
    if (!nRst) oPORT <= '0;
    else if (commit && wr && io) oPORT <= wdat;
`else
  logic unused_bits;
  assign unused_bits = ^{iPORT, iAddr[31:ADDR_W]};
  assign hit = 1'b0;
  assign rd_data = ram[idx];
  assign oPORT = '0;
`endif
  always_ff @(posedge iClk or negedge nRst)
    if (!nRst) begin
      state <= IDLE;
      cnt   <= '0;
      oRdy  <= 1'b0;
      oData <= '0;
      idx   <= '0;
      wdat  <= '0;
      wr    <= 1'b0;
      io    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          idx   <= iAddr[ADDR_W-1:0];
          wdat  <= iData;
          wr    <= iWrite;
          io    <= hit;
          cnt   <= WAIT_CYCLES[3:0];
          state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: if (!oRdy) begin
          oRdy  <= 1'b1;
          oData <= wr ? wdat : rd_data;
        end else if (!req) begin
          oRdy  <= 1'b0;
          oData <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for mem_responder (default parameters).
module tb_mem_responder;
  localparam int W = 2;
  logic clk = 1'b0;
  logic nRst;
  logic [31:0] iAddr, iData, iPORT, oData, oPORT;
  logic iRead, iWrite, oRdy;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  typedef struct {logic [31:0] data; int cyc;} exp_t;
  exp_t sb[$];
  logic prev = 1'b0;
  logic [31:0] cur = '0;

  mem_responder dut (
    .iClk(clk), .nRst(nRst), .iAddr(iAddr), .iData(iData), .iRead(iRead),
    .iWrite(iWrite), .oData(oData), .oRdy(oRdy), .iPORT(iPORT), .oPORT(oPORT)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Monitor: pops on every oRdy rise, checks data and latency, then watches the hold.
  always @(negedge clk) begin
    if (oRdy && !prev) begin
      if (sb.size() == 0) chk("unexpected_rdy", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata", oData, e.data);
        chk("latency", cyc, e.cyc);
        cur = e.data;
      end
    end else if (oRdy) chk("hold_data", oData, cur);
    prev = oRdy;
  end

  task automatic wait_rdy();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (oRdy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("timeout", 32'd1, 32'd0);
  endtask

  task automatic xact(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] e, input int hold, input bit scr);
    iRead = rd; iWrite = wr; iAddr = a; iData = d;
    sb.push_back('{e, cyc + 2 + W});
    if (scr) begin
      @(negedge clk);
      iAddr = 32'h7; iData = 32'h0BAD_0BAD; iWrite = 1'b1;
    end
    wait_rdy();
    repeat (hold) @(negedge clk);
    iRead = 1'b0; iWrite = 1'b0;
    @(negedge clk);
    chk("drop_rdy", {31'd0, oRdy}, 32'd0);
    chk("drop_data", oData, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_port, exp_io_rd, exp_alias;
`ifdef MEM_RESPONDER_IO_EN
    exp_port = 32'hF0F0; exp_io_rd = 32'h77; exp_alias = 32'hBBBB;
`else
    exp_port = 32'h0; exp_io_rd = 32'hF0F0; exp_alias = 32'hF0F0;
`endif
    nRst = 1'b0; iRead = 0; iWrite = 0; iAddr = '0; iData = '0; iPORT = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", {31'd0, oRdy}, 32'd0);
    chk("rst_data", oData, 32'd0);
    chk("rst_port", oPORT, 32'd0);
    nRst = 1'b1;
    @(negedge clk);
    xact(0, 1, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    xact(1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 5, 0);
    xact(0, 1, 32'h400, 32'h1234, 32'h1234, 0, 0);
    xact(1, 0, 32'h000, 32'h0, 32'h1234, 0, 0);
    xact(1, 1, 32'h7, 32'h55, 32'h55, 0, 0);
    xact(1, 0, 32'h7, 32'h0, 32'h55, 1, 0);
    xact(0, 1, 32'h3FF, 32'hCAFE, 32'hCAFE, 0, 0);
    xact(1, 0, 32'h7FF, 32'h0, 32'hCAFE, 0, 0);
    xact(1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1);
    xact(1, 0, 32'h7, 32'h0, 32'h55, 0, 0);
    // Abort a write to 0x5 mid-wait: the old word must survive.
    xact(0, 1, 32'h5, 32'h11, 32'h11, 0, 0);
    iWrite = 1'b1; iAddr = 32'h5; iData = 32'hAA;
    @(negedge clk);
    #2 nRst = 1'b0;
    #1;
    chk("abort_rdy", {31'd0, oRdy}, 32'd0);
    chk("abort_data", oData, 32'd0);
    chk("abort_port", oPORT, 32'd0);
    iWrite = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    xact(1, 0, 32'h5, 32'h0, 32'h11, 0, 0);
    // Reset while the response is being held.
    iRead = 1'b1; iAddr = 32'h10;
    sb.push_back('{32'hDEADBEEF, cyc + 2 + W});
    wait_rdy();
    #2 nRst = 1'b0;
    #1;
    chk("resp_rst_rdy", {31'd0, oRdy}, 32'd0);
    chk("resp_rst_data", oData, 32'd0);
    iRead = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    xact(0, 1, 32'h3F0, 32'hBBBB, 32'hBBBB, 0, 0);
    xact(0, 1, 32'hFFFF_FFF0, 32'hF0F0, 32'hF0F0, 0, 0);
    chk("io_port", oPORT, exp_port);
    iPORT = 32'h77;
    xact(1, 0, 32'hFFFF_FFF0, 32'h0, exp_io_rd, 0, 0);
    xact(1, 0, 32'h3F0, 32'h0, exp_alias, 0, 0);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
